red_seq_unit: RTL and testbench



---
 rtl/red_seq_unit.sv | 160 ++++++++++++++++
 tb/tb_red_seq_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/red_seq_unit.sv
// red_seq_unit -- multi-cycle segment reduction coprocessor for the ALU RED op.
//
// Splits A and B into NSEG = WIDTH/SEG_W two's-complement segments of SEG_W
// bits each and sums all 2*NSEG segments, PAR segment pairs per RUN cycle.
// The accumulated value is narrowed to SEG_W+1 bits and sign-extended to WIDTH.
//
// Parameters:
//   WIDTH  operand/result width (multiple of SEG_W)
//   SEG_W  segment width
//   PAR    segment pairs consumed per cycle (NSEG must be a multiple of PAR)
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only while busy=0 (IDLE or DONE)
//   A, B   in   operands, latched on an accepted start
//   busy   out  high while the reduction is running
//   done   out  one-cycle pulse, Sum valid from this cycle
//   Sum    out  result, held until the next op completes
//
// Build option:
//   RED_SAT_EN  when defined, the final narrowing saturates to
//               [-2^SEG_W, 2^SEG_W-1] instead of wrapping.

module red_seq_unit #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 8,
  parameter int PAR   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum
);

  localparam int NSEG  = WIDTH / SEG_W;
  localparam int ACC_W = SEG_W + $clog2(NSEG) + 2;
  localparam int KW    = $clog2(NSEG + 1);

  generate
    if (WIDTH % SEG_W != 0) begin : g_bad_seg
      $error("red_seq_unit: WIDTH must be a multiple of SEG_W");
    end
    if (NSEG % PAR != 0) begin : g_bad_par
      $error("red_seq_unit: NSEG must be a multiple of PAR");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0]        a_q, b_q;
  logic signed [ACC_W-1:0] acc, acc_n, step_sum;
  logic [KW-1:0]           k, k_n;
  logic                    accept;
  logic                    last;
  logic signed [SEG_W-1:0] seg_a, seg_b;
  logic signed [SEG_W:0]   narrow;
  logic [WIDTH-1:0]        sum_n;

`ifdef RED_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SEG_W){1'b0}}, {SEG_W{1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SEG_W){1'b1}}, {SEG_W{1'b0}}};
`endif

  // Segment datapath: add PAR pairs starting at index k.
  always_comb begin
    step_sum = '0;
    seg_a    = '0;
    seg_b    = '0;
    for (int unsigned i = 0; i < PAR; i++) begin
      seg_a    = SEG_W'(a_q >> ((32'(k) + i) * SEG_W));
      seg_b    = SEG_W'(b_q >> ((32'(k) + i) * SEG_W));
      step_sum = step_sum + ACC_W'(seg_a) + ACC_W'(seg_b);
    end
    acc_n = acc + step_sum;
    k_n   = KW'(32'(k) + PAR);
    last  = (32'(k) + PAR) >= NSEG;
  end

  // Final narrowing of the completed accumulator to SEG_W+1 bits.
  always_comb begin
`ifdef RED_SAT_EN
    if (acc_n > SAT_MAX)
      narrow = SAT_MAX[SEG_W:0];
    else if (acc_n < SAT_MIN)
      narrow = SAT_MIN[SEG_W:0];
    else
      narrow = acc_n[SEG_W:0];
`else
    narrow = acc_n[SEG_W:0];
`endif
    sum_n = WIDTH'(narrow);
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (last) state_n = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = S_RUN;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      Sum   <= '0;
      acc   <= '0;
      k     <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n == S_RUN);
      done  <= (state_n == S_DONE);
      if (accept) begin
        a_q <= A;
        b_q <= B;
        acc <= '0;
        k   <= '0;
      end else if (state == S_RUN) begin
        acc <= acc_n;
        k   <= k_n;
        // Sum takes the last step's contribution directly so it lands with done.
        if (last) Sum <= sum_n;
      end
    end
  end

endmodule

// File: tb/tb_red_seq_unit.sv
// Directed bench for red_seq_unit: default 16/8/1 instance plus a 32/8/2 instance.
module tb_red_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start_w;
  logic [15:0] a16, b16;
  logic [31:0] aw, bw;
  logic        busy, done, busy_w, done_w;
  logic [15:0] sum16;
  logic [31:0] sumw;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  red_seq_unit dut (
    .clk(clk), .rst(rst), .start(start), .A(a16), .B(b16),
    .busy(busy), .done(done), .Sum(sum16)
  );

  red_seq_unit #(.WIDTH(32), .SEG_W(8), .PAR(2)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .A(aw), .B(bw),
    .busy(busy_w), .done(done_w), .Sum(sumw)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic obs(input bit wide, output logic b, output logic d, output logic [31:0] s);
    if (wide) begin
      b = busy_w; d = done_w; s = sumw;
    end else begin
      b = busy; d = done; s = {16'h0, sum16};
    end
  endtask

  // One isolated op, start in cycle 0; expects busy in 1..2, done in 3.
  task automatic run_op(input bit wide, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] prev, input logic [31:0] exp, input string tag);
    logic ob, od;
    logic [31:0] os;
    obs(wide, ob, od, os);
    check_val({tag, " c0 busy"}, {31'h0, ob}, 32'h0);
    if (wide) begin start_w = 1'b1; aw = a; bw = b; end
    else begin start = 1'b1; a16 = a[15:0]; b16 = b[15:0]; end
    tick();
    start = 1'b0; start_w = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      obs(wide, ob, od, os);
      check_val($sformatf("%s c%0d busy", tag, c), {31'h0, ob}, 32'h1);
      check_val($sformatf("%s c%0d done", tag, c), {31'h0, od}, 32'h0);
      check_val($sformatf("%s c%0d hold", tag, c), os, prev);
      tick();
    end
    obs(wide, ob, od, os);
    check_val({tag, " c3 busy"}, {31'h0, ob}, 32'h0);
    check_val({tag, " c3 done"}, {31'h0, od}, 32'h1);
    check_val({tag, " c3 sum"}, os, exp);
    tick();
    obs(wide, ob, od, os);
    check_val({tag, " c4 done"}, {31'h0, od}, 32'h0);
    check_val({tag, " c4 sum"}, os, exp);
  endtask

  initial begin
    logic [31:0] exp_7f, exp_80, exp_w7f;
`ifdef RED_SAT_EN
    exp_7f  = 32'h0000_00FF;
    exp_80  = 32'h0000_FF00;
    exp_w7f = 32'h0000_00FF;
`else
    exp_7f  = 32'h0000_FFFC;
    exp_80  = 32'h0000_0000;
    exp_w7f = 32'hFFFF_FFF8;
`endif
    rst = 1'b1; start = 1'b0; start_w = 1'b0;
    a16 = '0; b16 = '0; aw = '0; bw = '0;
    repeat (3) tick();
    check_val("rst busy",   {31'h0, busy},   32'h0);
    check_val("rst done",   {31'h0, done},   32'h0);
    check_val("rst sum",    {16'h0, sum16},  32'h0);
    check_val("rst busy_w", {31'h0, busy_w}, 32'h0);
    check_val("rst sum_w",  sumw,            32'h0);
    rst = 1'b0;
    tick();

    run_op(1'b0, 32'h0102, 32'h0304, 32'h0000, 32'h000A, "basic");
    run_op(1'b0, 32'hFFFF, 32'hFFFF, 32'h000A, 32'hFFFC, "neg1");
    run_op(1'b0, 32'h7F7F, 32'h7F7F, 32'hFFFC, exp_7f,   "pos_max");
    run_op(1'b0, 32'h8080, 32'h8080, exp_7f,   exp_80,   "neg_min");

    // Start re-pulsed in cycle 1 with other operands must be ignored.
    start = 1'b1; a16 = 16'h0102; b16 = 16'h0304;
    tick();
    a16 = 16'h7F7F; b16 = 16'h7F7F;
    check_val("ign c1 busy", {31'h0, busy}, 32'h1);
    tick();
    start = 1'b0;
    check_val("ign c2 busy", {31'h0, busy}, 32'h1);
    check_val("ign c2 hold", {16'h0, sum16}, exp_80);
    tick();
    check_val("ign c3 done", {31'h0, done}, 32'h1);
    check_val("ign c3 sum",  {16'h0, sum16}, 32'h000A);
    tick();
    check_val("ign c4 busy", {31'h0, busy}, 32'h0);
    check_val("ign c4 done", {31'h0, done}, 32'h0);

    // Reset asserted during cycle 2 aborts the op.
    start = 1'b1; a16 = 16'h0304; b16 = 16'h0506;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      check_val($sformatf("abort c%0d done", c), {31'h0, done}, 32'h0);
      check_val($sformatf("abort c%0d busy", c), {31'h0, busy}, 32'h0);
      check_val($sformatf("abort c%0d sum", c), {16'h0, sum16}, 32'h0);
      tick();
    end

    // Back-to-back: new start in the DONE cycle.
    start = 1'b1; a16 = 16'h0102; b16 = 16'h0304;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_val("b2b c3 done", {31'h0, done}, 32'h1);
    check_val("b2b c3 sum",  {16'h0, sum16}, 32'h000A);
    start = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF;
    tick();
    start = 1'b0;
    check_val("b2b c4 busy", {31'h0, busy}, 32'h1);
    check_val("b2b c4 done", {31'h0, done}, 32'h0);
    check_val("b2b c4 hold", {16'h0, sum16}, 32'h000A);
    tick();
    check_val("b2b c5 done", {31'h0, done}, 32'h0);
    tick();
    check_val("b2b c6 done", {31'h0, done}, 32'h1);
    check_val("b2b c6 busy", {31'h0, busy}, 32'h0);
    check_val("b2b c6 sum",  {16'h0, sum16}, 32'hFFFC);
    tick();

    run_op(1'b1, 32'h0101_0101, 32'h0101_0101, 32'h0, 32'h0000_0008, "wide");
    run_op(1'b1, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h0000_0008, exp_w7f, "wide_max");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
